// File: rtl/pixel_stream_gen_if.sv
// Pixel source bus: pacing/start inputs, image memory read port and the
// output pixel stream with frame sideband.
interface pixel_stream_gen_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              iEnable;
  logic              iStart;
  logic [DATA_W-1:0] iMemData;
  logic              oMemRe;
  logic [ADDR_W-1:0] oMemAddr;
  logic              oValid;
  logic [DATA_W-1:0] oPixel;
  logic              oSof;
  logic              oEol;
  logic              oEof;
  logic              oDone;
  logic              oBusy;

  // master: the pixel generator itself
  modport master (
    input  iEnable, iStart, iMemData,
    output oMemRe, oMemAddr, oValid, oPixel, oSof, oEol, oEof, oDone, oBusy
  );

  // slave: the environment (pacer, memory, stream consumer)
  modport slave (
    output iEnable, iStart, iMemData,
    input  oMemRe, oMemAddr, oValid, oPixel, oSof, oEol, oEof, oDone, oBusy
  );
endinterface

// File: rtl/pixel_stream_gen.sv
// Enable-paced raster image source: one memory read per iEnable strobe,
// pixel emitted two cycles later with SOF/EOL/EOF sideband.
module pixel_stream_gen #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic               iClk,
  input  logic               iRst,
  pixel_stream_gen_if.master bus
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // stage 1: read issued, memory data arrives this cycle
  logic s1_valid_q, s1_sof_q, s1_eol_q, s1_eof_q;
  // stage 2: registered output beat
  logic              valid_q, sof_q, eol_q, eof_q;
  logic [DATA_W-1:0] pixel_q;

  logic rd_en;
  logic busy;
  logic last_pix;

  assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.iStart)         state_d = S_RUN;
      S_RUN:   if (rd_en && last_pix)  state_d = S_DRAIN;
      // the final beat is on the outputs now, so the frame is complete
      S_DRAIN: if (eof_q)              state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        rd_en = bus.iEnable;
        busy  = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (state_q == S_IDLE && bus.iStart) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (rd_en) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      pixel_q    <= '0;
    end else begin
      s1_valid_q <= rd_en;
      s1_sof_q   <= rd_en && (col_q == '0) && (row_q == '0);
      s1_eol_q   <= rd_en && (col_q == COL_LAST);
      s1_eof_q   <= rd_en && last_pix;
      valid_q    <= s1_valid_q;
      sof_q      <= s1_sof_q;
      eol_q      <= s1_eol_q;
      eof_q      <= s1_eof_q;
      if (s1_valid_q) pixel_q <= bus.iMemData;
    end
  end

  assign bus.oMemRe   = rd_en;
  assign bus.oMemAddr = addr_q;
  assign bus.oValid   = valid_q;
  assign bus.oPixel   = pixel_q;
  assign bus.oSof     = sof_q;
  assign bus.oEol     = eol_q;
  assign bus.oEof     = eof_q;
  assign bus.oDone    = eof_q;
  assign bus.oBusy    = busy;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Bench for pixel_stream_gen (4x2 image, word[a] = A0+a): frame-level model
// schedules each read's beat two cycles later and checks every cycle.
module tb_pixel_stream_gen;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int DW = 8;
  localparam int AW = 8;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  always #5 iClk = ~iClk;

  pixel_stream_gen_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pixel_stream_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(8'hA0 + a);

  always @(posedge iClk)
    if (bus.oMemRe) bus.iMemData <= mem[bus.oMemAddr];

  int n_cmp  = 0;
  int n_fail = 0;

  // frame model: 0 idle, 1 reading, 2 waiting for final beat
  int          cyc     = 0;
  int          m_phase = 0;
  int          m_reads = 0;
  int          m_addr  = 0;
  int          m_end   = 0;
  int          beat_at [int];
  logic [DW-1:0] m_pix = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_reads = 0;
    m_addr  = 0;
    m_pix   = '0;
    beat_at.delete();
  endtask

  task automatic check_outputs();
    int k;
    logic hb;
    hb = beat_at.exists(cyc);
    k  = hb ? beat_at[cyc] : -1;
    if (hb) m_pix = DW'(8'hA0 + k);
    chk("memre", 32'(bus.oMemRe), 32'((m_phase == 1) && bus.iEnable));
    chk("addr",  32'(bus.oMemAddr), 32'(AW'(m_addr)));
    chk("busy",  32'(bus.oBusy), 32'(m_phase != 0));
    chk("valid", 32'(bus.oValid), 32'(hb));
    chk("pixel", 32'(bus.oPixel), 32'(m_pix));
    chk("sof",   32'(bus.oSof), 32'(hb && k == 0));
    chk("eol",   32'(bus.oEol), 32'(hb && (k % W) == W - 1));
    chk("eof",   32'(bus.oEof), 32'(hb && k == N - 1));
    chk("done",  32'(bus.oDone), 32'(hb && k == N - 1));
  endtask

  // one clock cycle: drive inputs after the edge, check mid-cycle, advance model
  task automatic cycle(input logic en, input logic st, input logic rst);
    @(posedge iClk);
    #1;
    bus.iEnable = en;
    bus.iStart  = st;
    iRst        = rst;
    #2;
    if (!rst) model_reset();
    check_outputs();
    if (rst) begin
      if (m_phase == 0 && st) begin
        m_phase = 1;
        m_reads = 0;
        m_addr  = 0;
      end else if (m_phase == 1 && en) begin
        beat_at[cyc + 2] = m_reads;
        m_reads++;
        m_addr++;
        if (m_reads == N) begin
          m_phase = 2;
          m_end   = cyc + 2;
        end
      end else if (m_phase == 2 && cyc == m_end) begin
        m_phase = 0;
      end
    end
    cyc++;
  endtask

  task automatic async_reset_pulse();
    #1 iRst = 1'b0;
    #1;
    model_reset();
    check_outputs();
  endtask

  task automatic run_frame(input int density, input bool_restart_noise);
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic en, st;
      en = (density <= 1) ? 1'b1 : ($urandom_range(0, density - 1) == 0);
      st = bool_restart_noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      cycle(en, st, 1'b1);
      if (m_phase == 0) break;
    end
    for (int i = 0; i < 3; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1);
  endtask

  initial begin
    bus.iEnable  = 1'b0;
    bus.iStart   = 1'b0;
    bus.iMemData = '0;

    // reset held, then released with strobes running and no start
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) cycle((i % 5) == 0, 1'b0, 1'b1);

    // 1-in-5 pacing
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      cycle((i % 5) == 2, 1'b0, 1'b1);
      if (m_phase == 0) break;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);

    // enable tied high, start coincident with a strobe
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b1);

    // restart requests during RUN/DRAIN ignored, then an identical frame
    run_frame(3, 1);
    run_frame(1, 1);

    // randomized pacing density
    for (int f = 0; f < 4; f++) run_frame($urandom_range(1, 4), 0);

    // reset right after beat A4, then a fresh frame from address 0
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (beat_at.exists(cyc - 1) && beat_at[cyc - 1] == 4) break;
    end
    async_reset_pulse();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    run_frame(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
